// File: rtl/div_unit_pkg.sv
// Shared encodings for the iterative divider and the id/ex decode of DIV/DIVU.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam logic [7:0] DIV_ALU_OP  = 8'b0001_1010;
  localparam logic [7:0] DIVU_ALU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration on unsigned magnitudes: shift {rem, dvd},
// trial-subtract the divisor, shift the quotient bit into the dividend LSB.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] dvd_o
);

  logic [WIDTH:0] rem_ext;
  logic           q_bit;

  always_comb begin
    rem_ext = {rem_i, dvd_i[WIDTH-1]};
    q_bit   = (rem_ext >= {1'b0, dvs_i});
    // rem < dvs on entry, so the difference always fits in WIDTH bits.
    rem_o   = q_bit ? (rem_ext[WIDTH-1:0] - dvs_i) : rem_ext[WIDTH-1:0];
    dvd_o   = {dvd_i[WIDTH-2:0], q_bit};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned divider for the HI/LO path: {remainder, quotient}
// on result_o, start/ready handshake, busy stall, annul on flush.
module div_unit
  import div_unit_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opData1_i,
  input  logic [WIDTH-1:0]   opData2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_dvd;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .dvd_i (dvd_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .dvd_o (step_dvd)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    ready_d  = ready_q;

    case (state_q)
      DIV_FREE: begin
        ready_d = DIV_RESULT_NOT_READY;
        if (start_i == DIV_START) begin
          rem_d = '0;
          cnt_d = '0;
          if (opData2_i == '0) begin
            state_d = DIV_BYZERO;
            dvd_d   = opData1_i;
          end else begin
            state_d = DIV_ON;
            dvd_d   = (signed_i && opData1_i[WIDTH-1]) ? -opData1_i : opData1_i;
            dvs_d   = (signed_i && opData2_i[WIDTH-1]) ? -opData2_i : opData2_i;
            qneg_d  = signed_i && (opData1_i[WIDTH-1] ^ opData2_i[WIDTH-1]);
            rneg_d  = signed_i && opData1_i[WIDTH-1];
          end
        end
      end

      DIV_BYZERO: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else begin
          state_d  = DIV_END;
          result_d = {dvd_q, {WIDTH{1'b1}}};
          ready_d  = DIV_RESULT_READY;
        end
      end

      DIV_ON: begin
        // Annul wins even on the final iteration.
        if (annul_i) begin
          state_d = DIV_FREE;
        end else begin
          rem_d = step_rem;
          dvd_d = step_dvd;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_d  = DIV_END;
            cnt_d    = '0;
            ready_d  = DIV_RESULT_READY;
            result_d = {rneg_q ? -step_rem : step_rem,
                        qneg_q ? -step_dvd : step_dvd};
          end
        end
      end

      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_d = DIV_FREE;
          ready_d = DIV_RESULT_NOT_READY;
        end
      end

      default: begin
        state_d = DIV_FREE;
        ready_d = DIV_RESULT_NOT_READY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= DIV_RESULT_NOT_READY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  // The FREE-state stall is combinational on start_i, gated so reset clears it at once.
  assign busy_o   = rst && ((state_q == DIV_BYZERO) || (state_q == DIV_ON) ||
                            ((state_q == DIV_FREE) && start_i));
  assign ready_o  = ready_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed checks of div_unit at WIDTH=32 and WIDTH=8 against hand-computed results.
module tb_div_unit;

  logic        clk;
  logic        rst;

  logic        start32, annul32, sgn32;
  logic [31:0] a32, b32;
  logic [63:0] res32;
  logic        ready32, busy32;

  logic        start8, annul8, sgn8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
  logic        ready8, busy8;

  int n_cmp;
  int n_bad;

  div_unit #(.WIDTH(32)) dut32 (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start32),
    .annul_i   (annul32),
    .signed_i  (sgn32),
    .opData1_i (a32),
    .opData2_i (b32),
    .result_o  (res32),
    .ready_o   (ready32),
    .busy_o    (busy32)
  );

  div_unit #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start8),
    .annul_i   (annul8),
    .signed_i  (sgn8),
    .opData1_i (a8),
    .opData2_i (b8),
    .result_o  (res8),
    .ready_o   (ready8),
    .busy_o    (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges are counted from the edge after which start is raised; the edge
  // that samples start is +1.
  task automatic run32(input string tag, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp_res,
                       input int exp_lat);
    int lat;
    int busy_cnt;
    lat      = 0;
    busy_cnt = 0;
    start32 = 1'b1;
    sgn32   = sgn;
    a32     = a;
    b32     = b;
    #1;
    chk({tag, "_busy_start"}, 64'(busy32), 64'd1);
    busy_cnt = 1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 1) begin
        start32 = 1'b0;
        sgn32   = ~sgn;
        a32     = 32'hDEAD_BEEF;
        b32     = 32'h0000_0000;
      end
      if (ready32) begin
        lat = k;
        break;
      end
      if (busy32) busy_cnt++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_result"}, res32, exp_res);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    tick();
    chk({tag, "_ready_drop"}, 64'(ready32), 64'd0);
    chk({tag, "_result_held"}, res32, exp_res);
  endtask

  initial begin
    int lat;
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b0;
    start32 = 1'b0; annul32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
    start8  = 1'b0; annul8  = 1'b0; sgn8  = 1'b0; a8  = '0; b8  = '0;

    #3;
    chk("rst_result", res32, 64'd0);
    chk("rst_ready", 64'(ready32), 64'd0);
    chk("rst_busy", 64'(busy32), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    run32("u100_7", 1'b0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E}, 33);
    run32("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run32("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 33);
    run32("u_dz", 1'b0, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF}, 2);
    run32("s_dz", 1'b1, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF}, 2);

    // Annul at iteration 10, then an immediate 9 / 3.
    start32 = 1'b1; sgn32 = 1'b0; a32 = 32'd1000; b32 = 32'd3;
    tick();
    start32 = 1'b0;
    repeat (10) tick();
    annul32 = 1'b1;
    tick();
    annul32 = 1'b0;
    chk("annul10_busy", 64'(busy32), 64'd0);
    chk("annul10_ready", 64'(ready32), 64'd0);
    run32("u9_3", 1'b0, 32'd9, 32'd3, {32'h0000_0000, 32'h0000_0003}, 33);

    // Annul on the last iteration (counter == 31) still cancels.
    start32 = 1'b1; sgn32 = 1'b0; a32 = 32'd50; b32 = 32'd5;
    tick();
    start32 = 1'b0;
    repeat (31) tick();
    annul32 = 1'b1;
    tick();
    annul32 = 1'b0;
    chk("annul_last_ready", 64'(ready32), 64'd0);
    chk("annul_last_busy", 64'(busy32), 64'd0);
    chk("annul_last_result", res32, {32'h0000_0000, 32'h0000_0003});

    // start_i held high through END.
    start32 = 1'b1; sgn32 = 1'b0; a32 = 32'd100; b32 = 32'd7;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (ready32) begin
        lat = k;
        break;
      end
    end
    chk("hold_latency", 64'(lat), 64'd33);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_ready", 64'(ready32), 64'd1);
      chk("hold_result", res32, {32'h0000_0002, 32'h0000_000E});
    end
    start32 = 1'b0;
    tick();
    chk("hold_release_ready", 64'(ready32), 64'd0);
    chk("hold_release_busy", 64'(busy32), 64'd0);
    chk("hold_release_result", res32, {32'h0000_0002, 32'h0000_000E});
    repeat (3) tick();
    chk("no_relaunch_busy", 64'(busy32), 64'd0);
    chk("no_relaunch_ready", 64'(ready32), 64'd0);

    // Asynchronous reset in the middle of ON.
    start32 = 1'b1; sgn32 = 1'b0; a32 = 32'd77; b32 = 32'd4;
    tick();
    start32 = 1'b0;
    repeat (5) tick();
    chk("mid_on_busy", 64'(busy32), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_result", res32, 64'd0);
    chk("async_rst_ready", 64'(ready32), 64'd0);
    chk("async_rst_busy", 64'(busy32), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // WIDTH=8: 200 / 13 unsigned.
    start8 = 1'b1; sgn8 = 1'b0; a8 = 8'd200; b8 = 8'd13;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 1) begin
        start8 = 1'b0;
        a8     = 8'hFF;
        b8     = 8'h01;
      end
      if (ready8) begin
        lat = k;
        break;
      end
    end
    chk("w8_latency", 64'(lat), 64'd9);
    chk("w8_result", 64'(res8), 64'h050F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Parametrised iterative integer divider that serves the pipeline's HI/LO path.
- The EX stage issues DIV/DIVU through a start/ready handshake and holds the pipeline while `busy_o` is high.
- On completion, the remainder goes to HI and the quotient to LO, through the existing ex_mem / mem_wb / hilo_reg path.
- This generation adds a width parameter, a signed/unsigned mode, annul (flush cancel) and defined divide-by-zero results.

Parameters:
- WIDTH, 32, operand width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low.
- start_i  input  1  request division; sampled only in state FREE.
- annul_i  input  1  cancel the division in flight (pipeline flush).
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU; latched with start.
- opData1_i  input  WIDTH  dividend; latched with start.
- opData2_i  input  WIDTH  divisor; latched with start.
- result_o  output  2*WIDTH  {remainder, quotient}; the upper half goes to HI, the lower half to LO.
- ready_o  output  1  result_o is valid.
- busy_o  output  1  stall request to the pipeline.

Behaviour:
- Reset: rst low forces state FREE, counter 0, result_o 0, ready_o 0, busy_o 0, immediately and independent of clk.
- States (2-bit): FREE, BYZERO, ON, END.
- FREE:
  - start_i=1, divisor 0: go to BYZERO.
  - start_i=1, divisor nonzero: go to ON. Latch mode; latch absolute values of the operands if signed_i=1, raw values otherwise. Clear the partial remainder and the counter.
  - start_i=0: stay in FREE.
- ON:
  - One restoring iteration per cycle. Shift {rem, dvd} left by 1, trial-subtract the divisor, keep the difference if it is non-negative, and shift in the quotient bit.
  - The counter increments each cycle. The iteration with counter==WIDTH-1 is the last; the state then goes to END.
  - Sign fixup is applied when entering END. Quotient is negated if the operand signs differed. Remainder takes the sign of the dividend.
- BYZERO: next cycle go to END, with quotient = all ones and remainder = latched dividend (raw, unmodified).
- END:
  - ready_o=1 and result_o holds its value.
  - Stay in END while start_i=1. With start_i=0, go to FREE; ready_o drops the same edge and result_o keeps its last value.
- Latency:
  - Normal case: ready_o rises WIDTH+1 edges after the edge that sampled start.
  - Divide by zero: ready_o rises 2 edges after.
- busy_o: 1 in BYZERO and ON, and 1 in FREE combinationally while start_i=1 so the issuing instruction stalls. 0 in END and otherwise.
- Annul:
  - annul_i=1 in ON or BYZERO forces FREE next edge; ready_o never rises for that operation.
  - annul_i has priority over completion; annul on the last iteration still cancels.
  - annul_i has no effect in FREE or END.
- start_i is ignored in ON, BYZERO and END; a new operation needs a return to FREE.
- Signed overflow: most-negative / -1 yields quotient = most-negative (wrap) and remainder 0. No trap.
- The operands are latched, so input changes after the start cycle do not affect the result.

Decomposition:
- defines.v gains the following constants:
  - DivFree, DivByZero, DivOn, DivEnd as 2'b00..2'b11.
  - DivResultReady / DivResultNotReady.
  - DivStart / DivStop.
  - DivAluOp and DivuAluOp encodings for the id/ex decode.
- One combinational sub-module, div_step, parametrised by WIDTH. It takes {rem, dvd} and the divisor, and returns the next {rem, dvd} with the quotient bit. It is reusable for a later radix-4 variant.
- The sign fixup stays in div_unit.

Test Plan:
- WIDTH=32, unsigned, start with 100 / 7 -> ready_o at edge +33, result_o = {0x00000002, 0x0000000E}, busy_o high for 33 cycles.
- WIDTH=32, signed, 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Then 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- Divide by zero, 0x00001234 / 0 -> ready_o at edge +2, quotient 0xFFFFFFFF, remainder 0x00001234. Signed mode gives the same result.
- Annul at iteration 10 -> FREE next edge, busy_o low, ready_o never rises. An immediately following 9 / 3 returns {0, 3} with correct latency.
- Hold start_i high in END for 5 cycles -> the state stays in END and result_o is stable. Deasserting start_i -> FREE next edge, and no second division is launched.
- Drive rst low asynchronously mid-ON -> all outputs 0 with no clock edge. WIDTH=8 instance: 200 / 13 unsigned -> {5, 15} at edge +9.
